// File: rtl/matrix_buffer_reader_if.sv
// Buffer read port and lane byte stream of the matrix buffer reader.
// The master side is the reader; the slave side is the buffer/serializer environment.
interface matrix_buffer_reader_if #(
  parameter int BYTES_PER_BLOCK = 2250,
  parameter int LANE_COUNT      = 12
);
  localparam int AW = $clog2(BYTES_PER_BLOCK);

  logic                    O_read_enable;
  logic [AW-1:0]           O_read_address;
  logic [LANE_COUNT*8-1:0] I_data_flat;
  logic [LANE_COUNT*8-1:0] O_lane_data;
  logic                    O_lane_valid;
  logic                    I_lane_ready;

  modport master (
    output O_read_enable, O_read_address, O_lane_data, O_lane_valid,
    input  I_data_flat, I_lane_ready
  );

  modport slave (
    input  O_read_enable, O_read_address, O_lane_data, O_lane_valid,
    output I_data_flat, I_lane_ready
  );
endinterface

// File: rtl/matrix_buffer_reader.sv
// Streams one frame from the matrix buffer into a first-word fall-through FIFO feeding the lanes.
// Optional MATRIX_READER_STATS_EN adds a frame counter and a sticky start-overrun flag.
module matrix_buffer_reader #(
  parameter int BYTES_PER_BLOCK = 2250,
  parameter int LANE_COUNT      = 12,
  parameter int READ_LATENCY    = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  matrix_buffer_reader_if.master bus,
  input  logic                  I_data_valid,
  input  logic                  I_start,
  output logic                  O_busy,
  output logic                  O_frame_done
`ifdef MATRIX_READER_STATS_EN
  ,
  output logic [15:0]           O_frame_count,
  output logic                  O_start_overrun
`endif
);
  localparam int AW         = $clog2(BYTES_PER_BLOCK);
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int OW         = $clog2(2 * FIFO_DEPTH + 1);
  localparam int DW         = LANE_COUNT * 8;

  localparam logic [AW-1:0] LAST_ADDR = AW'(BYTES_PER_BLOCK - 1);
  localparam logic [OW-1:0] DEPTH_OW  = OW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [AW-1:0]           addr_q;
  logic [READ_LATENCY-1:0] tag_q;
  logic [OW-1:0]           count_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [DW-1:0]           fifo_mem [FIFO_DEPTH];

  logic [OW-1:0]           inflight;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    not_empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OW'(tag_q[i]);
    end
  end

  // Reads in flight are counted as occupied slots so returning data always finds room.
  assign issue     = (state_q == READ) && ((count_q + inflight) < DEPTH_OW);
  assign push      = tag_q[READ_LATENCY-1];
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && bus.I_lane_ready;

  assign bus.O_read_enable  = issue;
  assign bus.O_read_address = addr_q;
  assign bus.O_lane_valid   = not_empty;
  assign bus.O_lane_data    = not_empty ? fifo_mem[rd_ptr_q] : '0;
  assign O_busy             = (state_q != IDLE);
  assign O_frame_done       = (state_q == DONE);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      tag_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      tag_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + OW'(1);
      else if (!push && pop) count_q <= count_q - OW'(1);

      case (state_q)
        IDLE:  if (I_start && I_data_valid) state_q <= READ;
        READ: begin
          if (issue) begin
            if (addr_q == LAST_ADDR) state_q <= DRAIN;
            else                     addr_q  <= addr_q + AW'(1);
          end
        end
        DRAIN: if ((tag_q == '0) && !not_empty) state_q <= DONE;
        DONE: begin
          state_q <= IDLE;
          addr_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage carries data only; emptiness is tracked by count_q.
  always_ff @(posedge I_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.I_data_flat;
  end

`ifdef MATRIX_READER_STATS_EN
  logic [15:0] frame_count_q;
  logic        overrun_q;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      if (state_q == DONE) frame_count_q <= frame_count_q + 16'd1;
      if (I_start && O_busy) overrun_q <= 1'b1;
    end
  end

  assign O_frame_count   = frame_count_q;
  assign O_start_overrun = overrun_q;
`endif
endmodule

// File: tb/tb_matrix_buffer_reader.sv
// Directed bench for matrix_buffer_reader: an 8-byte frame at latency 2 and a 16-byte frame at latency 4.
// Lane i of buffer address a holds a ^ i; stats checks apply when MATRIX_READER_STATS_EN is defined.
module tb_matrix_buffer_reader;
  localparam int LC = 12;
  localparam int DW = LC * 8;

  logic clk = 1'b0;
  logic rst;
  logic dv;
  logic st_a;
  logic st_b;
  logic busy_a, fd_a, busy_b, fd_b;
`ifdef MATRIX_READER_STATS_EN
  logic [15:0] fc_a, fc_b;
  logic        ov_a, ov_b;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_buffer_reader_if #(.BYTES_PER_BLOCK(8),  .LANE_COUNT(LC)) ifa ();
  matrix_buffer_reader_if #(.BYTES_PER_BLOCK(16), .LANE_COUNT(LC)) ifb ();

  matrix_buffer_reader #(.BYTES_PER_BLOCK(8), .LANE_COUNT(LC), .READ_LATENCY(2)) dut_a (
    .I_clk(clk), .I_rst(rst), .bus(ifa.master), .I_data_valid(dv), .I_start(st_a),
    .O_busy(busy_a), .O_frame_done(fd_a)
`ifdef MATRIX_READER_STATS_EN
    , .O_frame_count(fc_a), .O_start_overrun(ov_a)
`endif
  );

  matrix_buffer_reader #(.BYTES_PER_BLOCK(16), .LANE_COUNT(LC), .READ_LATENCY(4)) dut_b (
    .I_clk(clk), .I_rst(rst), .bus(ifb.master), .I_data_valid(dv), .I_start(st_b),
    .O_busy(busy_b), .O_frame_done(fd_b)
`ifdef MATRIX_READER_STATS_EN
    , .O_frame_count(fc_b), .O_start_overrun(ov_b)
`endif
  );

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LC; i++) r[i*8 +: 8] = a ^ 8'(i);
    return r;
  endfunction

  // Buffer models: data appears READ_LATENCY cycles after the strobe, filler otherwise.
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb [4];
  always @(posedge clk) begin
    pa[0] <= ifa.O_read_enable ? pat(8'(ifa.O_read_address)) : {LC{8'hEE}};
    pa[1] <= pa[0];
    pb[0] <= ifb.O_read_enable ? pat(8'(ifb.O_read_address)) : {LC{8'hEE}};
    for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
  end
  assign ifa.I_data_flat = pa[1];
  assign ifb.I_data_flat = pb[3];

  int            iss_addr_a[$], iss_cyc_a[$], iss_addr_b[$];
  logic [DW-1:0] xfer_a[$], xfer_b[$];
  int            done_a, done_b, maxout_a, maxout_b;

  always @(negedge clk) begin
    if (iss_addr_a.size() - xfer_a.size() > maxout_a) maxout_a = iss_addr_a.size() - xfer_a.size();
    if (iss_addr_b.size() - xfer_b.size() > maxout_b) maxout_b = iss_addr_b.size() - xfer_b.size();
    if (ifa.O_read_enable) begin
      iss_addr_a.push_back(int'(ifa.O_read_address));
      iss_cyc_a.push_back(cyc);
    end
    if (ifb.O_read_enable) iss_addr_b.push_back(int'(ifb.O_read_address));
    if (ifa.O_lane_valid && ifa.I_lane_ready) xfer_a.push_back(ifa.O_lane_data);
    if (ifb.O_lane_valid && ifb.I_lane_ready) xfer_b.push_back(ifb.O_lane_data);
    if (fd_a) done_a = done_a + 1;
    if (fd_b) done_b = done_b + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_a();
    iss_addr_a.delete(); iss_cyc_a.delete(); xfer_a.delete();
    done_a = 0; maxout_a = 0;
  endtask

  task automatic wait_done_a();
    for (int n = 0; n < 300 && done_a == 0; n++) tick();
    repeat (3) tick();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"},  32'(busy_a), 32'd0);
    chk({tag, "_ren"},   32'(ifa.O_read_enable), 32'd0);
    chk({tag, "_raddr"}, 32'(ifa.O_read_address), 32'd0);
    chk({tag, "_lvld"},  32'(ifa.O_lane_valid), 32'd0);
    chkv({tag, "_ldata"}, ifa.O_lane_data, '0);
    chk({tag, "_done"},  32'(fd_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; dv = 1'b0; st_a = 1'b0; st_b = 1'b0;
    ifa.I_lane_ready = 1'b1; ifb.I_lane_ready = 1'b1;
    clr_a();
    iss_addr_b.delete(); xfer_b.delete(); done_b = 0; maxout_b = 0;
    tick(); tick();
    chk_reset_a("rst");
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame, ready held high.
    clr_a();
    dv = 1'b1; st_a = 1'b1; tick(); st_a = 1'b0;
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_ren0", 32'(ifa.O_read_enable), 32'd1);
    chk("t1_addr0", 32'(ifa.O_read_address), 32'd0);
    lat = 0;
    while (!ifa.O_lane_valid && lat < 20) begin tick(); lat++; end
    chk("t1_first_valid_lat", 32'(lat), 32'd3);
    wait_done_a();
    chk("t1_done_once", 32'(done_a), 32'd1);
    chk("t1_busy_end", 32'(busy_a), 32'd0);
    chk("t1_n_xfer", 32'(xfer_a.size()), 32'd8);
    chk("t1_n_iss", 32'(iss_addr_a.size()), 32'd8);
    for (int n = 0; n < 8; n++) begin
      chkv($sformatf("t1_xfer%0d", n), xfer_a[n], pat(8'(n)));
      chk($sformatf("t1_addr%0d", n), 32'(iss_addr_a[n]), 32'(n));
      chk($sformatf("t1_cyc%0d", n), 32'(iss_cyc_a[n] - iss_cyc_a[0]), 32'(n));
    end
    chk("t1_max_outstanding", 32'(maxout_a), 32'd3);

    // Ready toggling 1,0,0,1.
    clr_a();
    st_a = 1'b1; tick(); st_a = 1'b0;
    for (int n = 0; n < 300 && done_a == 0; n++) begin
      ifa.I_lane_ready = ((n % 4) == 0) || ((n % 4) == 3);
      tick();
    end
    ifa.I_lane_ready = 1'b1;
    repeat (3) tick();
    chk("t2_done_once", 32'(done_a), 32'd1);
    chk("t2_n_xfer", 32'(xfer_a.size()), 32'd8);
    for (int n = 0; n < 8; n++) chkv($sformatf("t2_xfer%0d", n), xfer_a[n], pat(8'(n)));
    chk("t2_max_outstanding", 32'(maxout_a), 32'd4);

    // Start without a valid frame.
    clr_a();
    dv = 1'b0; st_a = 1'b1; tick(); st_a = 1'b0;
    chk("t3_busy_now", 32'(busy_a), 32'd0);
    repeat (5) tick();
    chk("t3_busy_later", 32'(busy_a), 32'd0);
    chk("t3_n_iss", 32'(iss_addr_a.size()), 32'd0);
    chk("t3_done", 32'(done_a), 32'd0);

    // Reset at transfer 5, then a fresh frame.
    clr_a();
    dv = 1'b1; st_a = 1'b1; tick(); st_a = 1'b0;
    for (int n = 0; n < 100 && xfer_a.size() < 4; n++) tick();
    chk("t4_reached_xfer4", 32'(xfer_a.size()), 32'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_a("t4_midrst");
    repeat (6) tick();
    chk("t4_no_done", 32'(done_a), 32'd0);
    chk("t4_idle", 32'(busy_a), 32'd0);
    clr_a();
    st_a = 1'b1; tick(); st_a = 1'b0;
    wait_done_a();
    chk("t4_restart_addr0", 32'(iss_addr_a[0]), 32'd0);
    chk("t4_n_xfer", 32'(xfer_a.size()), 32'd8);
    chkv("t4_xfer0", xfer_a[0], pat(8'd0));
    chkv("t4_xfer7", xfer_a[7], pat(8'd7));

    // Second start mid-frame is ignored.
    rst = 1'b1; tick(); rst = 1'b0;
    clr_a();
`ifdef MATRIX_READER_STATS_EN
    chk("t5_fc_rst", 32'(fc_a), 32'd0);
    chk("t5_ov_rst", 32'(ov_a), 32'd0);
`endif
    st_a = 1'b1; tick(); st_a = 1'b0;
    for (int n = 0; n < 100 && xfer_a.size() < 2; n++) tick();
    st_a = 1'b1; tick(); st_a = 1'b0;
    chk("t5_busy_mid", 32'(busy_a), 32'd1);
    wait_done_a();
    repeat (4) tick();
    chk("t5_done_once", 32'(done_a), 32'd1);
    chk("t5_n_xfer", 32'(xfer_a.size()), 32'd8);
    chk("t5_n_iss", 32'(iss_addr_a.size()), 32'd8);
    chk("t5_idle", 32'(busy_a), 32'd0);
    chkv("t5_xfer7", xfer_a[7], pat(8'd7));
`ifdef MATRIX_READER_STATS_EN
    chk("t5_ov", 32'(ov_a), 32'd1);
    chk("t5_fc", 32'(fc_a), 32'd1);
`endif

    // Latency 4 with a 20-cycle stall.
    st_b = 1'b1; tick(); st_b = 1'b0;
    for (int n = 0; n < 100 && xfer_b.size() < 2; n++) tick();
    chk("t6_reached_xfer2", 32'(xfer_b.size()), 32'd2);
    ifb.I_lane_ready = 1'b0;
    repeat (20) tick();
    chk("t6_ren_stalled", 32'(ifb.O_read_enable), 32'd0);
    chk("t6_lvld", 32'(ifb.O_lane_valid), 32'd1);
    chk("t6_occupancy", 32'(iss_addr_b.size() - xfer_b.size()), 32'd6);
    chk("t6_max_outstanding", 32'(maxout_b), 32'd6);
    chkv("t6_head", ifb.O_lane_data, pat(8'd2));
    ifb.I_lane_ready = 1'b1;
    for (int n = 0; n < 300 && done_b == 0; n++) tick();
    repeat (3) tick();
    chk("t6_done_once", 32'(done_b), 32'd1);
    chk("t6_n_xfer", 32'(xfer_b.size()), 32'd16);
    chk("t6_n_iss", 32'(iss_addr_b.size()), 32'd16);
    for (int n = 0; n < 16; n++) chkv($sformatf("t6_xfer%0d", n), xfer_b[n], pat(8'(n)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix_buffer_reader.md
MATRIX_BUFFER_READER -- requirements
Module: matrix_buffer_reader

Interface
REQ-001 Parameter BYTES_PER_BLOCK, default 2250, gives the bytes per lane per frame and equals the read-port address count.
REQ-002 Parameter LANE_COUNT, default 12, gives the number of parallel byte lanes (BANK_COUNT*BLOCK_COUNT).
REQ-003 Parameter READ_LATENCY, default 2, gives the cycles from O_read_enable/O_read_address to valid I_data_flat; legal range 1..4.
REQ-004 Localparam AW = $clog2(BYTES_PER_BLOCK) and FIFO_DEPTH = READ_LATENCY+2.
REQ-005 I_clk  input  1  single clock for the whole block; all logic on rising edge.
REQ-006 I_rst  input  1  reset, synchronous, active-high.
REQ-007 I_data_valid  input  1  buffer holds a complete frame (high after first swap).
REQ-008 I_start  input  1  single-cycle request to stream one frame.
REQ-009 O_read_enable  output  1  buffer read strobe.
REQ-010 O_read_address  output  AW  common read address for all lanes.
REQ-011 I_data_flat  input  LANE_COUNT*8  read data; lane i at [i*8 +: 8].
REQ-012 O_lane_data  output  LANE_COUNT*8  byte per lane toward the SPI serializers.
REQ-013 O_lane_valid  output  1  O_lane_data valid.
REQ-014 I_lane_ready  input  1  all serializers accept; a transfer occurs when O_lane_valid && I_lane_ready.
REQ-015 O_busy  output  1  frame in progress.
REQ-016 O_frame_done  output  1  one-cycle pulse after the last byte transfers; usable as swap trigger.

Function
REQ-017 States: IDLE, READ, DRAIN, DONE.
REQ-018 IDLE->READ when I_start && I_data_valid; I_start with I_data_valid low is ignored.
REQ-019 READ issues O_read_enable with address 0..BYTES_PER_BLOCK-1 in ascending order, one address per issued cycle, never skipping or repeating.
REQ-020 A read issues only when FIFO occupancy plus in-flight reads < FIFO_DEPTH, so data returned after READ_LATENCY never overflows the FIFO.
REQ-021 A READ_LATENCY-deep valid shift register tracks in-flight reads; I_data_flat is written into the FIFO on the cycle its tag emerges.
REQ-022 READ->DRAIN in the cycle after address BYTES_PER_BLOCK-1 issues; the address counter then holds and O_read_enable is low.
REQ-023 DRAIN->DONE when no reads are in flight, the FIFO is empty, and the final transfer has occurred.
REQ-024 DONE asserts O_frame_done for exactly one cycle, then goes to IDLE.
REQ-025 O_lane_valid = FIFO not empty; O_lane_data = FIFO head (first-word fall-through); the head holds stable while I_lane_ready is low.
REQ-026 FIFO push and pop may occur in the same cycle with occupancy unchanged, including when the FIFO is full.
REQ-027 With I_lane_ready held high, throughput is one byte-vector per cycle after an initial latency of READ_LATENCY+1 cycles from I_start.
REQ-028 O_busy is high in READ, DRAIN and DONE.
REQ-029 I_start while O_busy is ignored.
REQ-030 I_data_valid falling mid-frame does not abort the frame.
REQ-031 Exactly BYTES_PER_BLOCK transfers occur per frame.

Reset
REQ-032 I_rst high at any clock edge forces IDLE, empties the FIFO, and clears in-flight tags and the address counter; reset mid-frame discards the frame with no O_frame_done.
REQ-033 Reset values: O_read_enable=0, O_read_address=0, O_lane_valid=0, O_lane_data=0, O_busy=0, O_frame_done=0.

Configuration
REQ-034 Macro MATRIX_READER_STATS_EN defined: adds output O_frame_count (16 bits), which increments on each O_frame_done, wraps 0xFFFF->0, and resets to 0.
REQ-035 MATRIX_READER_STATS_EN defined: adds output O_start_overrun (1 bit), a sticky flag set by I_start while O_busy and cleared only by reset.
REQ-036 MATRIX_READER_STATS_EN undefined: neither port nor its logic exists, and all other behaviour is identical.

Verification
REQ-037 BYTES_PER_BLOCK=8, LATENCY=2, ready=1, start with valid=1 -> addresses 0..7 on consecutive cycles; 8 transfers in order; first O_lane_valid 3 cycles after start; O_frame_done once.
REQ-038 Toggle ready 1,0,0,1 repeatedly with lane bytes = address^lane -> no lost or duplicated byte; the O_read_enable stall keeps occupancy+in-flight <= 4.
REQ-039 Start with I_data_valid=0 -> O_busy stays 0; no reads.
REQ-040 Assert I_rst at transfer 5 of 8 -> next cycle all outputs at reset values; a new start streams from address 0.
REQ-041 I_start again at transfer 3 -> ignored, frame ends after 8; with STATS_EN, O_start_overrun=1 and O_frame_count=1.
REQ-042 READ_LATENCY=4, ready low for 20 cycles mid-frame -> FIFO full at 6, O_read_enable low, data intact on resume.
